// File: rtl/i_memory_pkg.sv
// rtl/i_memory_pkg.sv - shared constants, MEM/WB latch type and byte helper for the i_memory stage
package i_memory_pkg;

    localparam int DEFAULT_DMEM_DEPTH = 256;
    localparam int DEFAULT_DMEM_AW    = 8;

    // Bit positions inside EX_MEM_wb_ctl
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // Bit positions inside EX_MEM_m_ctl
    localparam int M_BRANCH    = 2;
    localparam int M_MEM_READ  = 1;
    localparam int M_MEM_WRITE = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i_memory_if.sv
// rtl/i_memory_if.sv - EX/MEM inputs and MEM/WB outputs of the memory stage (EX_MEM_byte only with MEM_BYTE_ACCESS_EN)
interface i_memory_if;
    logic [1:0]  EX_MEM_wb_ctl;
    logic [2:0]  EX_MEM_m_ctl;
    logic [31:0] EX_MEM_npc;
    logic        EX_MEM_zero;
    logic [31:0] EX_MEM_alu_result;
    logic [31:0] EX_MEM_rdata2;
    logic [4:0]  EX_MEM_rd;
`ifdef MEM_BYTE_ACCESS_EN
    logic        EX_MEM_byte;
`endif
    logic        EX_MEM_PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_reg_write;
    logic [31:0] WB_mux5_write_data;

    modport master (
        output EX_MEM_wb_ctl, EX_MEM_m_ctl, EX_MEM_npc, EX_MEM_zero,
               EX_MEM_alu_result, EX_MEM_rdata2, EX_MEM_rd,
`ifdef MEM_BYTE_ACCESS_EN
        output EX_MEM_byte,
`endif
        input  EX_MEM_PCSrc, EX_MEM_NPC, MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data
    );

    modport slave (
        input  EX_MEM_wb_ctl, EX_MEM_m_ctl, EX_MEM_npc, EX_MEM_zero,
               EX_MEM_alu_result, EX_MEM_rdata2, EX_MEM_rd,
`ifdef MEM_BYTE_ACCESS_EN
        input  EX_MEM_byte,
`endif
        output EX_MEM_PCSrc, EX_MEM_NPC, MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data
    );
endinterface

// File: rtl/i_memory_data_memory.sv
// rtl/i_memory_data_memory.sv - data array: synchronous write, combinational read (byte enables with MEM_BYTE_ACCESS_EN)
import i_memory_pkg::*;

module data_memory #(
    parameter int DEPTH = DEFAULT_DMEM_DEPTH,
    parameter int AW    = DEFAULT_DMEM_AW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
`ifdef MEM_BYTE_ACCESS_EN
    input  logic [3:0]    i_byte_en,
`endif
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Contents are deliberately never reset; i_we already excludes reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
`ifdef MEM_BYTE_ACCESS_EN
            for (int b = 0; b < 4; b++) begin
                if (i_byte_en[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
`else
            r_mem[i_addr] <= i_wdata;
`endif
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/i_memory.sv
// rtl/i_memory.sv - MEM pipeline stage: branch resolve, data memory access and MEM/WB latch; MEM_BYTE_ACCESS_EN adds byte access
import i_memory_pkg::*;

module i_memory #(
    parameter int DMEM_DEPTH = DEFAULT_DMEM_DEPTH,
    parameter int DMEM_AW    = DEFAULT_DMEM_AW
) (
    input  logic     clk,
    input  logic     rst_n,
    i_memory_if.slave bus
);

    logic [DMEM_AW-1:0] w_addr;
    logic               w_mem_we;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rdata_word;
    logic [31:0]        w_rdata;
    mem_wb_t            r_mem_wb;
    logic               w_unused_bits;

    assign bus.EX_MEM_PCSrc = bus.EX_MEM_m_ctl[M_BRANCH] & bus.EX_MEM_zero;
    assign bus.EX_MEM_NPC   = bus.EX_MEM_npc;

    // Upper address bits drop out, so accesses wrap modulo DMEM_DEPTH.
    assign w_addr   = bus.EX_MEM_alu_result[DMEM_AW+1:2];
    assign w_mem_we = bus.EX_MEM_m_ctl[M_MEM_WRITE] & rst_n;

`ifdef MEM_BYTE_ACCESS_EN
    logic [3:0] w_byte_en;
    logic [7:0] w_rd_byte;

    assign w_byte_en = bus.EX_MEM_byte ? (4'b0001 << bus.EX_MEM_alu_result[1:0]) : 4'b1111;
    assign w_wdata   = bus.EX_MEM_byte ? {4{bus.EX_MEM_rdata2[7:0]}} : bus.EX_MEM_rdata2;
    assign w_rd_byte = pick_byte(w_rdata_word, bus.EX_MEM_alu_result[1:0]);
    assign w_rdata   = bus.EX_MEM_byte ? {{24{w_rd_byte[7]}}, w_rd_byte} : w_rdata_word;
`else
    assign w_wdata = bus.EX_MEM_rdata2;
    assign w_rdata = w_rdata_word;
`endif

    data_memory #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DMEM_AW)
    ) u_data_memory (
        .clk       (clk),
        .i_we      (w_mem_we),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
`ifdef MEM_BYTE_ACCESS_EN
        .i_byte_en (w_byte_en),
`endif
        .o_rdata   (w_rdata_word)
    );

    // Read data is sampled before the same-edge write lands, so read+write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_wb <= '0;
        end else begin
            r_mem_wb.rdata      <= w_rdata;
            r_mem_wb.alu_result <= bus.EX_MEM_alu_result;
            r_mem_wb.rd         <= bus.EX_MEM_rd;
            r_mem_wb.reg_write  <= bus.EX_MEM_wb_ctl[WB_REG_WRITE];
            r_mem_wb.mem_to_reg <= bus.EX_MEM_wb_ctl[WB_MEM_TO_REG];
        end
    end

    assign bus.MEM_WB_rd          = r_mem_wb.rd;
    assign bus.MEM_WB_reg_write   = r_mem_wb.reg_write;
    assign bus.WB_mux5_write_data = r_mem_wb.mem_to_reg ? r_mem_wb.rdata : r_mem_wb.alu_result;

    assign w_unused_bits = &{1'b0, bus.EX_MEM_m_ctl[M_MEM_READ],
                             bus.EX_MEM_alu_result[31:DMEM_AW+2], bus.EX_MEM_alu_result[1:0]};

endmodule

// File: tb/tb_i_memory.sv
// tb/tb_i_memory.sv - directed self-checking bench for i_memory (byte test only with MEM_BYTE_ACCESS_EN)
`timescale 1ns/1ps
module tb_i_memory;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    i_memory_if bus ();

    i_memory #(.DMEM_DEPTH(256), .DMEM_AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                         input logic [31:0] wdata, input logic [4:0] rd);
        bus.EX_MEM_wb_ctl     = wb;
        bus.EX_MEM_m_ctl      = m;
        bus.EX_MEM_alu_result = alu;
        bus.EX_MEM_rdata2     = wdata;
        bus.EX_MEM_rd         = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b11, 3'b100, 32'h0, 32'h0, 5'd7);
        bus.EX_MEM_zero = 1'b1;
        bus.EX_MEM_npc  = 32'h40;
        step();
        step();
        checks++; if (bus.MEM_WB_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b expected 0", bus.MEM_WB_reg_write); end
        checks++; if (bus.MEM_WB_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", bus.MEM_WB_rd); end
        checks++; if (bus.WB_mux5_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.WB_mux5_write_data); end
        checks++; if (bus.EX_MEM_PCSrc !== 1'b1) begin errors++; $display("FAIL reset_pcsrc: got %b expected 1", bus.EX_MEM_PCSrc); end
        checks++; if (bus.EX_MEM_NPC !== 32'h40) begin errors++; $display("FAIL reset_npc: got %h expected 40", bus.EX_MEM_NPC); end
        bus.EX_MEM_zero = 1'b0;
        rst_n = 1'b1;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        step();
    endtask

    task automatic test_store_load();
        drive(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
        step();
        drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd5);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL store_load_data: got %h expected deadbeef", bus.WB_mux5_write_data); end
        checks++; if (bus.MEM_WB_rd !== 5'd5) begin errors++; $display("FAIL store_load_rd: got %0d expected 5", bus.MEM_WB_rd); end
        checks++; if (bus.MEM_WB_reg_write !== 1'b1) begin errors++; $display("FAIL store_load_we: got %b expected 1", bus.MEM_WB_reg_write); end
    endtask

    task automatic test_alu_path();
        drive(2'b10, 3'b000, 32'h00000123, 32'hFFFF_FFFF, 5'd9);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'h123) begin errors++; $display("FAIL alu_data: got %h expected 123", bus.WB_mux5_write_data); end
        checks++; if (bus.MEM_WB_rd !== 5'd9) begin errors++; $display("FAIL alu_rd: got %0d expected 9", bus.MEM_WB_rd); end
        checks++; if (bus.MEM_WB_reg_write !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", bus.MEM_WB_reg_write); end
        drive(2'b00, 3'b000, 32'h0000_0456, 32'h0, 5'd2);
        step();
        checks++; if (bus.MEM_WB_reg_write !== 1'b0) begin errors++; $display("FAIL alu_we_off: got %b expected 0", bus.MEM_WB_reg_write); end
    endtask

    task automatic test_branch();
        drive(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
        bus.EX_MEM_zero = 1'b1;
        bus.EX_MEM_npc  = 32'h40;
        #1;
        checks++; if (bus.EX_MEM_PCSrc !== 1'b1) begin errors++; $display("FAIL branch_taken: got %b expected 1", bus.EX_MEM_PCSrc); end
        checks++; if (bus.EX_MEM_NPC !== 32'h40) begin errors++; $display("FAIL branch_npc: got %h expected 40", bus.EX_MEM_NPC); end
        bus.EX_MEM_zero = 1'b0;
        #1;
        checks++; if (bus.EX_MEM_PCSrc !== 1'b0) begin errors++; $display("FAIL branch_not_zero: got %b expected 0", bus.EX_MEM_PCSrc); end
        bus.EX_MEM_zero = 1'b1;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        #1;
        checks++; if (bus.EX_MEM_PCSrc !== 1'b0) begin errors++; $display("FAIL branch_no_branch: got %b expected 0", bus.EX_MEM_PCSrc); end
        bus.EX_MEM_zero = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        drive(2'b00, 3'b001, 32'h400, 32'h11, 5'd0);
        step();
        drive(2'b11, 3'b010, 32'h0, 32'h0, 5'd1);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'h11) begin errors++; $display("FAIL wrap_load: got %h expected 11", bus.WB_mux5_write_data); end
        drive(2'b11, 3'b010, 32'h3, 32'h0, 5'd1);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'h11) begin errors++; $display("FAIL word_low_bits: got %h expected 11", bus.WB_mux5_write_data); end
    endtask

    task automatic test_read_write_same();
        drive(2'b00, 3'b001, 32'h30, 32'hA, 5'd0);
        step();
        drive(2'b11, 3'b011, 32'h30, 32'hB, 5'd6);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'hA) begin errors++; $display("FAIL rw_old_word: got %h expected a", bus.WB_mux5_write_data); end
        drive(2'b11, 3'b010, 32'h30, 32'h0, 5'd6);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'hB) begin errors++; $display("FAIL rw_new_word: got %h expected b", bus.WB_mux5_write_data); end
    endtask

    task automatic test_back_to_back();
        drive(2'b00, 3'b001, 32'h44, 32'h1, 5'd0);
        step();
        drive(2'b00, 3'b001, 32'h44, 32'h2, 5'd0);
        step();
        drive(2'b11, 3'b010, 32'h44, 32'h0, 5'd8);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'h2) begin errors++; $display("FAIL b2b_last_wins: got %h expected 2", bus.WB_mux5_write_data); end
    endtask

    task automatic test_reset_mid_store();
        drive(2'b00, 3'b001, 32'h20, 32'h77, 5'd0);
        step();
        drive(2'b10, 3'b000, 32'h20, 32'h0, 5'd3);
        step();
        drive(2'b00, 3'b001, 32'h20, 32'h55, 5'd0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.MEM_WB_reg_write !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", bus.MEM_WB_reg_write); end
        checks++; if (bus.MEM_WB_rd !== 5'd0) begin errors++; $display("FAIL midrst_rd: got %0d expected 0", bus.MEM_WB_rd); end
        checks++; if (bus.WB_mux5_write_data !== 32'h0) begin errors++; $display("FAIL midrst_wdata: got %h expected 0", bus.WB_mux5_write_data); end
        step();
        rst_n = 1'b1;
        drive(2'b11, 3'b010, 32'h20, 32'h0, 5'd4);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'h77) begin errors++; $display("FAIL midrst_preserved: got %h expected 77", bus.WB_mux5_write_data); end
    endtask

`ifdef MEM_BYTE_ACCESS_EN
    task automatic test_byte_access();
        drive(2'b00, 3'b001, 32'h8, 32'h0, 5'd0);
        step();
        bus.EX_MEM_byte = 1'b1;
        drive(2'b00, 3'b001, 32'h9, 32'h80, 5'd0);
        step();
        bus.EX_MEM_byte = 1'b0;
        drive(2'b11, 3'b010, 32'h8, 32'h0, 5'd10);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'h00008000) begin errors++; $display("FAIL byte_word_load: got %h expected 00008000", bus.WB_mux5_write_data); end
        bus.EX_MEM_byte = 1'b1;
        drive(2'b11, 3'b010, 32'h9, 32'h0, 5'd10);
        step();
        checks++; if (bus.WB_mux5_write_data !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_sext: got %h expected ffffff80", bus.WB_mux5_write_data); end
        bus.EX_MEM_byte = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        bus.EX_MEM_zero = 1'b0;
        bus.EX_MEM_npc  = 32'h0;
`ifdef MEM_BYTE_ACCESS_EN
        bus.EX_MEM_byte = 1'b0;
`endif
        test_reset();
        test_store_load();
        test_alu_path();
        test_branch();
        test_wrap();
        test_read_write_same();
        test_back_to_back();
        test_reset_mid_store();
`ifdef MEM_BYTE_ACCESS_EN
        test_byte_access();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i_memory.md
I_MEMORY -- requirements
Module: i_memory

Interface
REQ-001 SHALL provide parameter DMEM_DEPTH, default 256, number of 32-bit data-memory words (power of two).
REQ-002 SHALL provide parameter DMEM_AW, default 8, word-address width, equal to log2(DMEM_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port EX_MEM_wb_ctl  input  2  writeback control: [1] reg_write, [0] mem_to_reg.
REQ-006 SHALL have port EX_MEM_m_ctl  input  3  memory control: [2] branch, [1] mem_read, [0] mem_write.
REQ-007 SHALL have port EX_MEM_npc  input  32  branch target address.
REQ-008 SHALL have port EX_MEM_zero  input  1  ALU zero flag.
REQ-009 SHALL have port EX_MEM_alu_result  input  32  ALU result or memory byte address.
REQ-010 SHALL have port EX_MEM_rdata2  input  32  store data.
REQ-011 SHALL have port EX_MEM_rd  input  5  destination register.
REQ-012 SHALL have port EX_MEM_byte  input  1  byte-access qualifier; present only with MEM_BYTE_ACCESS_EN.
REQ-013 SHALL have port EX_MEM_PCSrc  output  1  branch-taken select to fetch.
REQ-014 SHALL have port EX_MEM_NPC  output  32  redirect address to fetch.
REQ-015 SHALL have port MEM_WB_rd  output  5  writeback destination to decode.
REQ-016 SHALL have port MEM_WB_reg_write  output  1  register-file write enable to decode.
REQ-017 SHALL have port WB_mux5_write_data  output  32  register-file write data to decode.

Function
REQ-018 EX_MEM_PCSrc SHALL equal branch AND EX_MEM_zero, combinationally, with zero cycles of latency.
REQ-019 EX_MEM_NPC SHALL pass EX_MEM_npc through combinationally.
REQ-020 Word address SHALL be EX_MEM_alu_result[DMEM_AW+1:2].
  - Upper address bits SHALL be ignored, so addresses wrap modulo DMEM_DEPTH.
  - In word mode, bits [1:0] SHALL be ignored.
REQ-021 When mem_write=1 at a rising edge, the addressed word SHALL be written with EX_MEM_rdata2 at that edge.
REQ-022 Read data SHALL be the combinational array value at the current address, captured into the MEM/WB latch.
  - A load therefore reaches writeback 1 cycle after presentation.
REQ-023 At every rising edge, the MEM/WB latch SHALL capture: read data, alu_result, rd, reg_write and mem_to_reg.
  - There is no stall or enable; the latch updates every cycle.
REQ-024 WB_mux5_write_data SHALL be a combinational function of the latch: latched read data when mem_to_reg=1, else latched alu_result.
REQ-025 MEM_WB_rd and MEM_WB_reg_write SHALL be driven directly from the latch.
REQ-026 If mem_read and mem_write are both set, the write SHALL occur and the latch SHALL capture the pre-write (old) word.
REQ-027 If mem_read=0, read data SHALL still be latched; the value is don't-care unless mem_to_reg=1.
REQ-028 Writes to the same address on consecutive cycles SHALL both take effect in order; the last write wins.

Reset
REQ-029 While rst_n=0, all MEM/WB latch fields SHALL be 0 asynchronously.
  - Consequently MEM_WB_reg_write=0, MEM_WB_rd=0 and WB_mux5_write_data=0.
REQ-030 While rst_n=0, data-memory writes SHALL be suppressed, including when reset is asserted mid-store.
REQ-031 Data-memory contents SHALL NOT be reset.
REQ-032 EX_MEM_PCSrc and EX_MEM_NPC are combinational and SHALL remain input-driven during reset.

Configuration
REQ-033 Macro MEM_BYTE_ACCESS_EN SHALL enable byte access.
  - With the macro, when EX_MEM_byte=1, stores SHALL write only byte lane alu_result[1:0] with rdata2[7:0].
  - With the macro, when EX_MEM_byte=1, loads SHALL return the selected byte sign-extended to 32 bits.
  - Without the macro, the EX_MEM_byte port and all lane logic SHALL be absent, and every access SHALL be a full word.

Structure
REQ-034 A shared package SHALL hold: the control-bit index constants (WB_REG_WRITE, WB_MEM_TO_REG, M_BRANCH, M_MEM_READ, M_MEM_WRITE) and the DMEM_DEPTH default.
REQ-035 The data array SHALL be a sub-module named data_memory: synchronous write, combinational read, plus byte enables under the macro.

Verification
REQ-036 Store then load: store 0xDEADBEEF to address 0x10, then load from 0x10 with mem_to_reg=1 and rd=5 -> next cycle WB_mux5_write_data=0xDEADBEEF, MEM_WB_rd=5, MEM_WB_reg_write=1.
REQ-037 ALU path: alu_result=0x00000123, mem_to_reg=0, reg_write=1, rd=9 -> next cycle WB_mux5_write_data=0x123, MEM_WB_rd=9.
REQ-038 Branch: branch=1, zero=1, npc=0x40 -> same cycle EX_MEM_PCSrc=1, EX_MEM_NPC=0x40; with zero=0 -> EX_MEM_PCSrc=0.
REQ-039 Wrap: store 0x11 to 0x400 with DMEM_DEPTH=256, then load from 0x0 -> 0x11.
REQ-040 Reset mid-store: rst_n=0 during a store of 0x55 to 0x20 (which previously held 0x77) -> outputs 0 immediately; after release, load from 0x20 -> 0x77.
REQ-041 With MEM_BYTE_ACCESS_EN: word 0x00000000 at 0x8, byte store 0x80 to 0x9 -> word load from 0x8 returns 0x00008000; byte load from 0x9 returns 0xFFFFFF80.
